// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle for the icache refill controller: fetch request/response,
// valid-bit directory, tag array, data array and the memory burst-read port.
// The controller connects through the master modport; the surrounding
// arrays, fetch unit and memory use the slave modport.
interface icache_refill_ctrl_if;

   // fetch request / response
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   // valid-bit directory (combinational read, write on clock edge)
   logic [7:0]  dir_addr;
   logic        dir_en;
   logic        dir_din;
   logic        dir_dout;

   // tag array, read port indexed by dir_addr
   logic [18:0] tag_rdata;
   logic        tag_we;
   logic [18:0] tag_wdata;

   // data array, addressed as {index, word}
   logic [10:0] data_addr;
   logic [31:0] data_rdata;
   logic        data_we;
   logic [31:0] data_wdata;

   // memory burst read
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [31:0] ret_data;

   modport master (
      input  req_valid, req_addr,
      output req_ready, rsp_valid, rsp_data,
      output dir_addr, dir_en, dir_din,
      input  dir_dout,
      input  tag_rdata,
      output tag_we, tag_wdata,
      output data_addr, data_we, data_wdata,
      input  data_rdata,
      output rd_req, rd_addr,
      input  rd_rdy, ret_valid, ret_last, ret_data
   );

   modport slave (
      output req_valid, req_addr,
      input  req_ready, rsp_valid, rsp_data,
      input  dir_addr, dir_en, dir_din,
      output dir_dout,
      output tag_rdata,
      input  tag_we, tag_wdata,
      input  data_addr, data_we, data_wdata,
      output data_rdata,
      input  rd_req, rd_addr,
      output rd_rdy, ret_valid, ret_last, ret_data
   );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller.
// Serves one fetch at a time: looks the latched address up in the external
// valid-bit directory and tag array, returns the word from the data array on
// a hit, and on a miss issues a burst read, writes every returned beat into
// the data array and validates the line on the last beat.
// Build option: define ICACHE_INV_EN to add the inv_req/inv_done ports and a
// state that clears all 256 directory entries, one per cycle.
module icache_refill_ctrl #(
   parameter int LINE_WORDS = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
`ifdef ICACHE_INV_EN
   input  logic                 inv_req,
   output logic                 inv_done,
`endif
   icache_refill_ctrl_if.master bus
);

   // address layout: tag | index | word offset | byte offset
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = 8;
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      REFILL,
      RESP
`ifdef ICACHE_INV_EN
      , INV
`endif
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [31:0]      addr_q;    // address of the fetch being served
   logic [OFF_W-1:0] cnt_q;     // beat counter inside the refill burst
   logic [31:0]      word_q;    // word returned on the response

   logic [TAG_W-1:0] tag_q;
   logic [IDX_W-1:0] idx_q;
   logic [OFF_W-1:0] off_q;

   assign tag_q = addr_q[31 -: TAG_W];
   assign idx_q = addr_q[2 + OFF_W +: IDX_W];
   assign off_q = addr_q[2 +: OFF_W];

   // byte-offset bits are latched with the address but never looked at
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_q[1:0];

   logic hit;
   logic beat;
   logic beat_last;
   logic inv_start;
   logic accept;

   assign hit       = bus.dir_dout && (bus.tag_rdata == tag_q);
   assign beat      = (state_q == REFILL) && bus.ret_valid;
   assign beat_last = beat && bus.ret_last;

`ifdef ICACHE_INV_EN
   logic [IDX_W-1:0] inv_cnt_q;
   logic             inv_last;
   logic             inv_done_c;

   // an invalidate request wins over a fetch presented in the same cycle
   assign inv_start = (state_q == IDLE) && inv_req;
   assign inv_last  = (inv_cnt_q == '1);
   assign inv_done  = inv_done_c;
`else
   assign inv_start = 1'b0;
`endif

   assign accept = (state_q == IDLE) && bus.req_valid && !inv_start;

   // combinational strobes and addresses driven onto the bus
   logic             req_ready_c;
   logic             rsp_valid_c;
   logic             rd_req_c;
   logic             data_we_c;
   logic             dir_en_c;
   logic             dir_din_c;
   logic             tag_we_c;
   logic [IDX_W-1:0] dir_addr_c;
   logic [10:0]      data_addr_c;

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_data   = word_q;
   assign bus.rd_req     = rd_req_c;
   assign bus.rd_addr    = {tag_q, idx_q, 5'b0};
   assign bus.data_we    = data_we_c;
   assign bus.data_addr  = data_addr_c;
   assign bus.data_wdata = bus.ret_data;
   assign bus.dir_en     = dir_en_c;
   assign bus.dir_din    = dir_din_c;
   assign bus.dir_addr   = dir_addr_c;
   assign bus.tag_we     = tag_we_c;
   assign bus.tag_wdata  = tag_q;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // next-state decode and per-state strobes
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      state_d     = state_q;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      rd_req_c    = 1'b0;
      data_we_c   = 1'b0;
      dir_en_c    = 1'b0;
      dir_din_c   = 1'b0;
      tag_we_c    = 1'b0;
      dir_addr_c  = idx_q;
      data_addr_c = {idx_q, off_q};
`ifdef ICACHE_INV_EN
      inv_done_c  = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            req_ready_c = !inv_start;
            if (inv_start) begin
`ifdef ICACHE_INV_EN
               state_d = INV;
`endif
            end else if (bus.req_valid) begin
               state_d = LOOKUP;
            end
         end

         LOOKUP: begin
            state_d = hit ? RESP : MISS;
         end

         MISS: begin
            rd_req_c = 1'b1;
            if (bus.rd_rdy) state_d = REFILL;
         end

         REFILL: begin
            data_addr_c = {idx_q, cnt_q};
            data_we_c   = bus.ret_valid;
            if (beat_last) begin
               // the line becomes valid together with its final beat
               tag_we_c  = 1'b1;
               dir_en_c  = 1'b1;
               dir_din_c = 1'b1;
               state_d   = RESP;
            end
         end

         RESP: begin
            rsp_valid_c = 1'b1;
            state_d     = IDLE;
         end

`ifdef ICACHE_INV_EN
         INV: begin
            dir_addr_c = inv_cnt_q;
            dir_en_c   = 1'b1;
            dir_din_c  = 1'b0;
            inv_done_c = inv_last;
            if (inv_last) state_d = IDLE;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // latch the fetch address when a request is accepted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     addr_q <= '0;
      else if (accept) addr_q <= bus.req_addr;
   end

   // beat counter: zero outside a refill, advances on each returned beat
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                 cnt_q <= '0;
      else if (state_q != REFILL)  cnt_q <= '0;
      else if (beat_last)          cnt_q <= '0;
      else if (beat)               cnt_q <= cnt_q + 1'b1;
   end

   // response word: array data on a hit, or the beat matching the offset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                              word_q <= '0;
      else if ((state_q == LOOKUP) && hit)      word_q <= bus.data_rdata;
      else if (beat && (cnt_q == off_q))        word_q <= bus.ret_data;
   end

`ifdef ICACHE_INV_EN
   // directory sweep pointer for the invalidate state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)              inv_cnt_q <= '0;
      else if (state_q == INV)  inv_cnt_q <= inv_cnt_q + 1'b1;
      else                      inv_cnt_q <= '0;
   end
`endif

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, 8, 32-bit words per line; offset = addr[4:2], index = addr[12:5], tag = addr[31:13].
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid in 1, req_addr in 32, req_ready out 1: fetch request handshake.
REQ-005 SHALL have ports rsp_valid out 1, rsp_data out 32: fetch response, one-cycle pulse.
REQ-006 SHALL have ports dir_addr out 8, dir_en out 1, dir_din out 1, dir_dout in 1: valid-bit directory, combinational read, write on clk edge.
REQ-007 SHALL have ports tag_rdata in 19 (combinational, indexed by dir_addr), tag_we out 1, tag_wdata out 19.
REQ-008 SHALL have ports data_addr out 11 ({index,word}), data_rdata in 32 (combinational), data_we out 1, data_wdata out 32.
REQ-009 SHALL have ports rd_req out 1, rd_addr out 32, rd_rdy in 1, ret_valid in 1, ret_last in 1, ret_data in 32: memory burst read.

Function
REQ-010 SHALL implement states IDLE, LOOKUP, MISS, REFILL, RESP (plus INV, see Configuration).
REQ-011 IDLE: req_ready=1; req_valid=1 latches req_addr, next LOOKUP; otherwise stay.
REQ-012 req_ready SHALL be 0 in every state except IDLE; requests are never queued.
REQ-013 LOOKUP: dir_addr=latched index, data_addr={index,offset}; hit = dir_dout AND tag_rdata==latched tag.
REQ-014 Hit: capture data_rdata, next RESP; rsp_valid asserts exactly 2 cycles after the accepting edge.
REQ-015 Miss: next MISS; rd_req=1, rd_addr={tag,index,5'b0} held constant until rd_rdy=1, then REFILL.
REQ-016 REFILL: each ret_valid cycle writes ret_data with data_we=1, data_addr={index,cnt}; 3-bit cnt starts at 0 and increments per beat.
REQ-017 Beat with cnt==offset SHALL be captured as the response word.
REQ-018 Beat with ret_last=1: same cycle tag_we=1 (tag_wdata=latched tag), dir_en=1, dir_din=1; next RESP.
REQ-019 ret_last before cnt==LINE_WORDS-1 SHALL still end REFILL and validate the line; ret_last absent at cnt==7 SHALL wrap cnt to 0 and continue.
REQ-020 ret_valid=0 cycles in REFILL SHALL stall without writes.
REQ-021 RESP: rsp_valid=1, rsp_data=captured word for one cycle, next IDLE.
REQ-022 dir_en, tag_we, data_we, rd_req SHALL be 0 except where stated above.
REQ-023 Outputs SHALL be Moore outputs of state/registers only, except dir/tag/data addresses derived from latched address.

Reset
REQ-024 resetn=0 SHALL asynchronously force IDLE, cnt=0, latched address=0, rsp_data=0, all strobes 0; req_ready=1 once resetn=1.
REQ-025 Reset mid-REFILL SHALL abandon the line without setting its valid bit; remaining ret beats after reset SHALL be ignored in IDLE.

Configuration
REQ-026 Macro ICACHE_INV_EN defined: adds ports inv_req in 1, inv_done out 1 and state INV.
REQ-027 With ICACHE_INV_EN: inv_req in IDLE has priority over req_valid (req_ready=0 that cycle); INV writes dir_din=0, dir_en=1, dir_addr=0..255 one per cycle, inv_done=1 on the cycle writing 255, then IDLE.
REQ-028 Without ICACHE_INV_EN: no inv ports, no INV state; directory cleared only by its own reset.

Verification
REQ-029 Reset, req 0x0000_1024 with dir_dout=0 -> rd_req, rd_addr=0x0000_1020; 8 beats 0xA0..0xA7 -> data_we x8, dir_en/din=1 and tag_we on beat 8, rsp_data=0xA1.
REQ-030 Repeat 0x0000_1024 with dir_dout=1, tag match, data_rdata=0xA1 -> rsp_valid 2 cycles after accept, no rd_req.
REQ-031 dir_dout=1, tag mismatch at addr 0x0000_3024 -> miss path, rd_addr=0x0000_3020.
REQ-032 rd_rdy held 0 five cycles, ret_valid gaps between beats -> rd_addr stable, no extra data_we, cnt correct.
REQ-033 resetn pulsed low after beat 3 -> IDLE immediately, no dir_en; next req same addr misses.
REQ-034 ICACHE_INV_EN build: inv_req with concurrent req_valid -> 256 dir writes din=0, inv_done on 256th, then req accepted and misses.
